vga_capture320: RTL and testbench

- Receive-side counterpart of the 480x320 VGA display path. Takes a 640x480@60 VGA stream (Hsync, Vsync, 8-bit R/G/B) on the pixel clock and tracks sync timing.
- Writes one 480x320 window of pixels into a result/frame memory through a simple write port.
- Used to capture frames back from a display path or an external source for processing and loopback checking.

---
 rtl/vga_capture320.sv | 186 ++++++++++++++++++
 tb/tb_vga_capture320.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_capture320.sv
// Captures a WIDTH x HEIGHT window of a 640x480 VGA stream into a write port; `CAPTURE_RGB_EN widens wr_data to {R,G,B}.
// Write strobe lands 2 clocks after the pixel is on the inputs; no backpressure, the memory must take every write.
module vga_capture320 #(
    parameter int H_TOTAL = 800,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_TOTAL = 525,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int WIDTH   = 480,
    parameter int HEIGHT  = 320,
    parameter int X0      = 0,
    parameter int Y0      = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        Hsync,
    input  logic        Vsync,
    input  logic [7:0]  R,
    input  logic [7:0]  G,
    input  logic [7:0]  B,
    output logic        wr_en,
    output logic [17:0] wr_addr,
`ifdef CAPTURE_RGB_EN
    output logic [23:0] wr_data,
`else
    output logic [7:0]  wr_data,
`endif
    output logic        busy,
    output logic        frame_done,
    output logic        sync_err
);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

    localparam logic [9:0]  CNT_MAX   = 10'd1023;
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [10:0] X_LO      = 11'(H_SYNC + H_BP + X0);
    localparam logic [10:0] X_HI      = 11'(H_SYNC + H_BP + X0 + WIDTH);
    localparam logic [10:0] Y_LO      = 11'(V_SYNC + V_BP + Y0);
    localparam logic [10:0] Y_HI      = 11'(V_SYNC + V_BP + Y0 + HEIGHT);
    localparam logic [17:0] ADDR_LAST = 18'(WIDTH * HEIGHT - 1);

    state_t      state, state_nxt;
    logic        hs_r, vs_r, hs_d, vs_d;
    logic [7:0]  r_r;
    logic [9:0]  h_cnt, v_cnt;
    logic        h_at_end;
    logic        hs_pre, vs_pre, hs_fall, vs_fall;
    logic        in_win, line_bad;
    logic        do_wr, err;
    logic [17:0] addr;
    logic        chk;
    logic        unused_cfg;

`ifdef CAPTURE_RGB_EN
    logic [7:0]  g_r, b_r;
    logic [23:0] pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_r <= '0;
            b_r <= '0;
        end else begin
            g_r <= G;
            b_r <= B;
        end
    end

    assign pix        = {r_r, g_r, b_r};
    assign unused_cfg = (V_TOTAL > 0);
`else
    logic [7:0]  pix;

    assign pix        = r_r;
    assign unused_cfg = (V_TOTAL > 0) ^ (^{G, B});
`endif

    // Counters switch one cycle early so that h_cnt/v_cnt line up with the stage-1 pixel.
    assign hs_pre  = hs_r & ~Hsync;
    assign vs_pre  = vs_r & ~Vsync;
    assign hs_fall = hs_d & ~hs_r;
    assign vs_fall = vs_d & ~vs_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_r     <= 1'b0;
            vs_r     <= 1'b0;
            hs_d     <= 1'b0;
            vs_d     <= 1'b0;
            r_r      <= '0;
            h_cnt    <= '0;
            v_cnt    <= '0;
            h_at_end <= 1'b0;
        end else begin
            hs_r     <= Hsync;
            vs_r     <= Vsync;
            hs_d     <= hs_r;
            vs_d     <= vs_r;
            r_r      <= R;
            h_at_end <= (h_cnt == H_LAST);
            if (hs_pre)
                h_cnt <= '0;
            else if (h_cnt != CNT_MAX)
                h_cnt <= h_cnt + 10'd1;
            if (vs_pre)
                v_cnt <= '0;
            else if (hs_pre && (v_cnt != CNT_MAX))
                v_cnt <= v_cnt + 10'd1;
        end
    end

    assign in_win = ({1'b0, h_cnt} >= X_LO) && ({1'b0, h_cnt} < X_HI) &&
                    ({1'b0, v_cnt} >= Y_LO) && ({1'b0, v_cnt} < Y_HI);

    // h_at_end holds the count of the cycle before the edge, i.e. the finished line's last index.
    assign line_bad = hs_fall && chk && !h_at_end;

    always_comb begin
        state_nxt = state;
        do_wr     = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = WAIT_VS;
            end
            WAIT_VS: begin
                if (vs_fall)
                    state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (line_bad || vs_fall) begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end else if (in_win) begin
                    do_wr = 1'b1;
                    if (addr == ADDR_LAST)
                        state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            chk        <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_en      <= do_wr;
            frame_done <= (state == DONE);
            if (do_wr) begin
                wr_addr <= addr;
                wr_data <= pix;
                addr    <= addr + 18'd1;
            end
            if ((state == IDLE) && start)
                sync_err <= 1'b0;
            else if (err)
                sync_err <= 1'b1;
            if ((state == WAIT_VS) && vs_fall) begin
                addr <= '0;
                chk  <= 1'b0;
            end else if ((state == CAPTURE) && hs_fall) begin
                chk <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_vga_capture320.sv
module tb_vga_capture320;

    localparam int HT = 40, HS = 4, HB = 4, VT = 30, VS = 2, VB = 3;
    localparam int W = 24, H = 16, X0 = 3, Y0 = 2;
    localparam int SHORT_LEN = 36;
`ifdef CAPTURE_RGB_EN
    localparam int DW = 24;
`else
    localparam int DW = 8;
`endif

    typedef struct {
        int            cyc;
        int            addr;
        logic [DW-1:0] dat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, start, Hsync, Vsync;
    logic [7:0]    R, G, B;
    logic          wr_en, busy, frame_done, sync_err;
    logic [17:0]   wr_addr;
    logic [DW-1:0] wr_data;

    vga_capture320 #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB),
        .WIDTH(W), .HEIGHT(H), .X0(X0), .Y0(Y0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Hsync(Hsync), .Vsync(Vsync),
        .R(R), .G(G), .B(B), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   total = 0, bad = 0;
    exp_t q[$];
    bit   m_armed = 0, m_cap = 0, m_err = 0;
    int   done_cyc = -1;
    int   n_wr = 0;
    bit   auto_start = 0, nominal = 0;
    int   short_l = -1, rst_at = -1, rst_hold = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy();
        return m_armed || m_cap || (cyc < done_cyc);
    endfunction

    // One pixel clock: check what the DUT shows now, update the model, drive the next pixel.
    task automatic tick(input logic hs, input logic vs, input logic st, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b, input int h, input int l);
        bit            exp_we, st_eff;
        int            x, y, a;
        logic [DW-1:0] pd;
        exp_t          e;
        @(negedge clk);
        if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) rst_n = 1'b1;
        end
        exp_we = (q.size() > 0) && (q[0].cyc == cyc);
        chk("wr_en", wr_en, exp_we);
        if (wr_en === 1'b1) n_wr++;
        if (exp_we) begin
            e = q.pop_front();
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.dat);
            if (nominal && e.addr == W + 1) chk("data_at_w_plus_1", wr_data, 2);
            if (e.addr == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_wr_en", wr_en, 0);
                chk("rst_wr_addr", wr_addr, 0);
                chk("rst_wr_data", wr_data, 0);
                chk("rst_busy", busy, 0);
                chk("rst_frame_done", frame_done, 0);
                chk("rst_sync_err", sync_err, 0);
                q.delete();
                m_armed = 0; m_cap = 0; m_err = 0; done_cyc = -1;
                rst_hold = 4; rst_at = -1;
            end
        end
        chk("frame_done", frame_done, (cyc == done_cyc));

        st_eff = st;
        if (auto_start && cyc == done_cyc) begin
            st_eff = 1'b1;
            auto_start = 0;
        end
        if (st_eff && !m_busy()) begin
            m_armed = 1;
            m_err = 0;
        end
        if (l == 0 && h == 0 && m_armed) begin
            m_armed = 0;
            m_cap = 1;
        end
        if (short_l >= 0 && l == short_l + 1 && h == 0 && m_cap) begin
            m_cap = 0;
            m_err = 1;
        end
`ifdef CAPTURE_RGB_EN
        pd = {r, g, b};
`else
        pd = r;
`endif
        x = h - (HS + HB) - X0;
        y = l - (VS + VB) - Y0;
        if (m_cap && x >= 0 && x < W && y >= 0 && y < H) begin
            a = y * W + x;
            e.cyc = cyc + 2; e.addr = a; e.dat = pd;
            q.push_back(e);
            if (a == W * H - 1) begin
                m_cap = 0;
                done_cyc = cyc + 3;
            end
        end
        start = st_eff; Hsync = hs; Vsync = vs; R = r; G = g; B = b;
    endtask

    task automatic drive_frame(input int start_l, input int busy_l);
        int         len, x, y;
        logic [7:0] r;
        for (int l = 0; l < VT; l++) begin
            len = (l == short_l) ? SHORT_LEN : HT;
            for (int h = 0; h < len; h++) begin
                x = h - (HS + HB) - X0;
                y = l - (VS + VB) - Y0;
                r = nominal ? 8'(x + y) : 8'($urandom);
                tick(h >= HS, l >= VS, (h == 5) && (l == start_l || l == busy_l),
                     r, 8'($urandom), 8'($urandom), h, l);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; Hsync = 1'b1; Vsync = 1'b1; R = '0; G = '0; B = '0;
        repeat (3) @(negedge clk);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_wr_data", wr_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_sync_err", sync_err, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, -1, -1);
        chk("idle_busy", busy, 0);

        drive_frame(20, -1);
        chk("armed_busy", busy, m_busy());

        nominal = 1; auto_start = 1; n_wr = 0;
        drive_frame(-1, 12);
        nominal = 0;
        chk("nominal_count", n_wr, W * H);
        chk("restart_busy", busy, m_busy());

        n_wr = 0;
        drive_frame(-1, -1);
        chk("restart_frame_count", n_wr, W * H);
        chk("after_frame_busy", busy, m_busy());
        chk("after_frame_err", sync_err, m_err);

        drive_frame(20, -1);
        short_l = 10; n_wr = 0;
        drive_frame(-1, -1);
        short_l = -1;
        chk("short_err", sync_err, m_err);
        chk("short_busy", busy, m_busy());
        chk("short_count", n_wr, 4 * W);

        drive_frame(2, -1);
        chk("rearm_err_clear", sync_err, m_err);
        chk("rearm_busy", busy, m_busy());

        rst_at = 100;
        drive_frame(-1, -1);
        chk("post_reset_busy", busy, m_busy());
        n_wr = 0;
        drive_frame(-1, -1);
        chk("no_start_count", n_wr, 0);
        chk("no_start_busy", busy, m_busy());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
